hex_seg_driver: RTL and testbench

Post-processing stage between one HEX parallel-output port and the physical seven-segment pins. Takes the 7-bit segment pattern the port produces and adds three effects before it reaches the pins:
- PWM brightness control;
- programmable blinking;
- an optional "flash on change" burst, which gives visual feedback on password digit entry.

Run-time control is a small Avalon-MM slave on the Nios system bus.

---
 rtl/hex_seg_driver_pkg.sv | 34 +++
 rtl/hex_blink_timer.sv | 58 +++++
 rtl/hex_seg_driver.sv | 127 ++++++++++++
 tb/tb_hex_seg_driver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_seg_driver_pkg.sv
// Shared constants for the seven-segment post-processing stage: register map,
// CTRL bit positions, blank pattern, flash FSM encoding and the duty clamp.
package hex_seg_driver_pkg;

    localparam logic [1:0] ADDR_CTRL       = 2'd0;
    localparam logic [1:0] ADDR_BRIGHT     = 2'd1;
    localparam logic [1:0] ADDR_BLINK_HALF = 2'd2;
    localparam logic [1:0] ADDR_STATUS     = 2'd3;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_INVERT   = 2;
    localparam int CTRL_FLASH    = 3;

    localparam logic [6:0]  BLANK_PATTERN    = 7'h7F;
    localparam logic [4:0]  DUTY_MAX         = 5'd16;
    localparam logic [15:0] BLINK_HALF_RESET = 16'd500;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLASH = 1'b1;

    typedef struct packed {
        logic flash_on_change;
        logic invert;
        logic blink_en;
        logic enable;
    } ctrl_t;

    // Anything above full brightness saturates rather than wrapping.
    function automatic logic [4:0] clamp_duty(input logic [31:0] value);
        return (value > 32'd16) ? DUTY_MAX : value[4:0];
    endfunction

endpackage

// File: rtl/hex_blink_timer.sv
// Blink timebase: divides clk into ticks, counts ticks per half-period and
// toggles phase; a restart realigns everything to the start of a visible half.
module hex_blink_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        restart,
    input  logic        half_wr,
    input  logic [15:0] half_period,
    output logic        phase,
    output logic        toggle
);
    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0] tick_cnt;
    logic [15:0]   half_cnt;
    logic [15:0]   half_last;
    logic          tick;
    logic          wrap;

    // A programmed half-period of 0 behaves as 1; >= keeps a shrunken limit from stalling.
    assign half_last = (half_period == 16'd0) ? 16'd0 : half_period - 16'd1;
    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign wrap      = tick && (half_cnt >= half_last);
    assign toggle    = run && !restart && !half_wr && wrap;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            half_cnt <= '0;
            phase    <= 1'b1;
        end else begin
            if (restart || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;

            if (restart || !run) begin
                half_cnt <= '0;
                phase    <= 1'b1;
            end else if (half_wr) begin
                half_cnt <= '0;
            end else if (tick) begin
                if (wrap) begin
                    half_cnt <= '0;
                    phase    <= ~phase;
                end else begin
                    half_cnt <= half_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/hex_seg_driver.sv
// Seven-segment pin driver: PWM dimming, blinking and flash-on-change bursts
// applied to an active-low segment pattern, controlled over Avalon-MM.
module hex_seg_driver
    import hex_seg_driver_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int FLASH_HALVES = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  seg_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [6:0]  seg_out
);
    ctrl_t       ctrl;
    logic [4:0]  duty;
    logic [15:0] blink_half;
    logic [6:0]  seg_q;
    logic [6:0]  seg_prev;
    logic [3:0]  pwm_cnt;
    logic [0:0]  flash_state;
    logic [7:0]  flash_rem;

    logic wr_en, wr_ctrl, wr_bright, wr_half;
    logic blink_start, flash_enter, restart;
    logic flash_active, blinking, phase, toggle;
    logic pwm_lit, blank;

    assign wr_en     = chipselect && !write_n;
    assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
    assign wr_bright = wr_en && (address == ADDR_BRIGHT);
    assign wr_half   = wr_en && (address == ADDR_BLINK_HALF);

    // Turning blinking on realigns the timer so the digit is visible at once.
    assign blink_start  = wr_ctrl && writedata[CTRL_BLINK_EN] && !ctrl.blink_en;
    assign flash_enter  = ctrl.flash_on_change && (seg_q != seg_prev);
    assign restart      = flash_enter || blink_start;
    assign flash_active = (flash_state == ST_FLASH);
    assign blinking     = ctrl.blink_en || flash_active;

    assign pwm_lit = ({1'b0, pwm_cnt} < duty);
    assign blank   = !ctrl.enable || !pwm_lit || (blinking && !phase);

    hex_blink_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (blinking),
        .restart     (restart),
        .half_wr     (wr_half),
        .half_period (blink_half),
        .phase       (phase),
        .toggle      (toggle)
    );

    // NOTE: asynchronous active-low reset; every register has a defined reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl       <= '{flash_on_change: 1'b0, invert: 1'b0, blink_en: 1'b0, enable: 1'b1};
            duty       <= DUTY_MAX;
            blink_half <= BLINK_HALF_RESET;
        end else begin
            if (wr_ctrl) begin
                ctrl.enable          <= writedata[CTRL_ENABLE];
                ctrl.blink_en        <= writedata[CTRL_BLINK_EN];
                ctrl.invert          <= writedata[CTRL_INVERT];
                ctrl.flash_on_change <= writedata[CTRL_FLASH];
            end
            if (wr_bright)
                duty <= clamp_duty(writedata);
            if (wr_half)
                blink_half <= writedata[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_state <= ST_IDLE;
            flash_rem   <= '0;
        end else if (!ctrl.flash_on_change) begin
            flash_state <= ST_IDLE;
            flash_rem   <= '0;
        end else if (flash_enter) begin
            flash_state <= ST_FLASH;
            flash_rem   <= 8'(FLASH_HALVES);
        end else if (flash_active && toggle) begin
            flash_rem <= flash_rem - 8'd1;
            if (flash_rem == 8'd1)
                flash_state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q    <= BLANK_PATTERN;
            seg_prev <= BLANK_PATTERN;
            pwm_cnt  <= '0;
            seg_out  <= BLANK_PATTERN;
        end else begin
            seg_q    <= seg_in;
            seg_prev <= seg_q;
            pwm_cnt  <= pwm_cnt + 4'd1;
            seg_out  <= (blank ? BLANK_PATTERN : seg_q) ^ {7{ctrl.invert}};
        end
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:       readdata[3:0]  = ctrl;
            ADDR_BRIGHT:     readdata[4:0]  = duty;
            ADDR_BLINK_HALF: readdata[15:0] = blink_half;
            ADDR_STATUS: begin
                readdata[0]     = phase;
                readdata[1]     = flash_active;
                readdata[10:8]  = flash_rem[2:0];
                readdata[22:16] = seg_q;
            end
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_hex_seg_driver.sv
// Directed bench for hex_seg_driver with a fast blink timebase (TICK_DIV=4).
module tb_hex_seg_driver;
    import hex_seg_driver_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  seg_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [6:0]  seg_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hex_seg_driver #(.TICK_DIV(4), .FLASH_HALVES(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seg_in     (seg_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg_out    (seg_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Samples seg_out on n falling edges, classifying blank/visible samples.
    task automatic observe(input int n, input int base, input logic [6:0] vis,
                           output int blanks, output int visible, output int runs,
                           output int first_b, output int last_b);
        logic prev;
        prev = 1'b0;
        blanks = 0; visible = 0; runs = 0; first_b = -1; last_b = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (seg_out === BLANK_PATTERN) begin
                blanks++;
                if (!prev) runs++;
                if (first_b < 0) first_b = base + i;
                last_b = base + i;
                prev = 1'b1;
            end else begin
                if (seg_out === vis) visible++;
                prev = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [6:0]  s [0:39];
        int blanks, visible, runs, first_b, last_b, bad;

        reset_n = 1'b0; seg_in = 7'h40; address = ADDR_CTRL;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("seg_out_in_reset", {25'd0, seg_out}, 32'h7F);
        bus_read(ADDR_CTRL, rd);       check("rst_ctrl", rd, 32'd1);
        bus_read(ADDR_BRIGHT, rd);     check("rst_bright", rd, 32'd16);
        bus_read(ADDR_BLINK_HALF, rd); check("rst_blink_half", rd, 32'd500);
        bus_read(ADDR_STATUS, rd);     check("rst_status", rd, 32'h007F0001);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); check("latency_clk1", {25'd0, seg_out}, 32'h7F);
        @(negedge clk); check("latency_clk2", {25'd0, seg_out}, 32'h40);

        // PWM brightness
        bus_write(ADDR_BRIGHT, 32'd4);
        bus_read(ADDR_BRIGHT, rd); check("bright4_rb", rd, 32'd4);
        observe(32, 0, 7'h40, blanks, visible, runs, first_b, last_b);
        check("pwm4_lit", visible, 8);
        check("pwm4_dark", blanks, 24);
        bus_write(ADDR_BRIGHT, 32'd31);
        bus_read(ADDR_BRIGHT, rd); check("bright31_rb", rd, 32'd16);
        observe(32, 0, 7'h40, blanks, visible, runs, first_b, last_b);
        check("pwm16_lit", visible, 32);
        bus_write(ADDR_BRIGHT, 32'd0);
        bus_read(ADDR_BRIGHT, rd); check("bright0_rb", rd, 32'd0);
        observe(32, 0, 7'h40, blanks, visible, runs, first_b, last_b);
        check("pwm0_dark", blanks, 32);
        bus_write(ADDR_BRIGHT, 32'd16);

        // Blinking: 3 ticks x 4 clk = 12 clk per half, starting visible
        bus_write(ADDR_BLINK_HALF, 32'd3);
        bus_write(ADDR_CTRL, 32'd3);
        bad = 0;
        for (int n = 1; n <= 48; n++) begin
            @(negedge clk);
            if (seg_out !== ((((n - 1) / 12) % 2 == 0) ? 7'h40 : BLANK_PATTERN)) bad++;
        end
        check("blink12_pattern_errs", bad, 0);

        // Half-period 0 behaves as 1 tick: 4 clk visible / 4 clk blank
        bus_write(ADDR_BLINK_HALF, 32'd0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            s[i] = seg_out;
        end
        bad = 0; blanks = 0;
        for (int i = 0; i < 32; i++) begin
            if (s[i] === s[i + 4] || s[i] !== s[i + 8]) bad++;
            if (s[i] === BLANK_PATTERN) blanks++;
        end
        check("blink4_period_errs", bad, 0);
        check("blink4_blank_cnt", blanks, 16);

        // Flash burst: 6 half-periods of 2 ticks x 4 clk
        bus_write(ADDR_CTRL, 32'd1);
        bus_write(ADDR_BLINK_HALF, 32'd2);
        bus_write(ADDR_CTRL, 32'd9);
        repeat (2) @(negedge clk);
        check("pre_flash_steady", {25'd0, seg_out}, 32'h40);
        address = ADDR_STATUS;
        seg_in = 7'h79;
        @(negedge clk); check("flash_n0_status", readdata, 32'h00790001);
        @(negedge clk); check("flash_n1_status", readdata, 32'h00790603);
        observe(88, 2, 7'h79, blanks, visible, runs, first_b, last_b);
        check("flash_blank_cnt", blanks, 24);
        check("flash_first_blank", first_b, 10);
        check("flash_last_blank", last_b, 49);
        check("flash_runs", runs, 3);
        check("flash_final_seg", {25'd0, seg_out}, 32'h79);
        check("flash_final_status", readdata, 32'h00790001);

        // Second change at half-period 3 restarts the burst at 6
        seg_in = 7'h24;
        repeat (21) @(negedge clk);
        check("restart_mid_status", readdata, 32'h00240403);
        seg_in = 7'h30;
        repeat (2) @(negedge clk);
        check("restart_entry_status", readdata, 32'h00300603);
        observe(68, 2, 7'h30, blanks, visible, runs, first_b, last_b);
        check("restart_blank_cnt", blanks, 24);
        check("restart_runs", runs, 3);
        check("restart_last_blank", last_b, 49);
        check("restart_final_seg", {25'd0, seg_out}, 32'h30);

        // Invert and enable
        bus_write(ADDR_CTRL, 32'd5);
        seg_in = 7'h40;
        repeat (3) @(negedge clk);
        check("invert_seg", {25'd0, seg_out}, 32'h3F);
        bus_write(ADDR_CTRL, 32'd4);
        @(negedge clk);
        check("invert_disabled", {25'd0, seg_out}, 32'h00);

        // Reset in the middle of a burst
        bus_write(ADDR_CTRL, 32'd9);
        address = ADDR_STATUS;
        seg_in = 7'h79;
        repeat (6) @(negedge clk);
        check("burst_before_reset", readdata, 32'h00790603);
        check("visible_before_reset", {25'd0, seg_out}, 32'h79);
        reset_n = 1'b0;
        #1;
        check("async_reset_seg", {25'd0, seg_out}, 32'h7F);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_reset_status", readdata, 32'h007F0001);
        observe(20, 0, 7'h79, blanks, visible, runs, first_b, last_b);
        check("post_reset_blanks", blanks, 1);
        check("post_reset_visible", visible, 19);
        check("post_reset_no_flash", readdata, 32'h00790001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
